otter_hazard_ctrl: RTL and testbench
====================================

# otter_hazard_ctrl

Pipeline sequencing controller for the 5-stage OTTER CPU (IF, DE, EX, MEM, WB). It owns the per-stage valid bits and generates PC write enable, pipeline stall and flush controls, and registered EX-operand forwarding selects. It also selects the PC source, including the trap vector. It sequences interrupt entry by draining the pipeline before redirecting fetch to MTVEC.

## Interface
Parameters:
- DRAIN_CYCLES, 3, number of bubble cycles spent in DRAIN before TRAP (EX, MEM and WB emptying).

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- DE_RS1_ADDR, DE_RS2_ADDR  in  5 each  source registers of the instruction in DE.
- DE_RS1_USED, DE_RS2_USED  in  1 each  the DE instruction reads rs1/rs2.
- DE_PC  in  32  PC of the DE instruction (trap return address).
- EX_RD_ADDR, MEM_RD_ADDR, WB_RD_ADDR  in  5 each  destination register per stage.
- EX_REGWRITE, MEM_REGWRITE, WB_REGWRITE  in  1 each  raw decoder regWrite per stage; qualified internally by the valid bits.
- EX_MEMREAD  in  1  the EX instruction is a load.
- EX_PC_SOURCE  in  3  PC source computed in EX (0 = PC+4, 1 = JALR, 2 = BRANCH, 3 = JAL).
- INTR  in  1  level interrupt request.
- MIE  in  1  interrupt enable from CSR.
- PC_WRITE  out  1  PC register enable.
- PC_SOURCE  out  3  to PC mux; 4 = MTVEC.
- IF_DE_WRITE  out  1  IF/DE register enable (0 = hold).
- DE_VALID, EX_VALID, MEM_VALID, WB_VALID  out  1 each  stage contains a live instruction.
- FWD_A, FWD_B  out  2 each  EX operand select: 0 = register file, 1 = MEM ALU result, 2 = WB write data, 3 = WB-hold register (last cycle's wd).
- EPC_SAVE  out  1  one-cycle strobe to capture EPC_VALUE.
- EPC_VALUE  out  32  trap return PC.
- INT_TAKEN  out  1  one-cycle strobe in TRAP; CSR clears MIE.

## Operation
- Valid bits shift each cycle: WB <= MEM, MEM <= EX, EX <= DE & ~kill_de, DE <= fetch_ok & ~flush.
- Qualified producer per stage: X_REGWRITE & X_VALID & (X_RD_ADDR != 0).
- Load-use stall: qualified EX producer, EX_MEMREAD, and EX_RD_ADDR matches a used DE source.
  - Effect: PC_WRITE = 0, IF_DE_WRITE = 0, kill_de = 1 (bubble into EX), DE_VALID held.
  - The stall lasts exactly one cycle; after it the load is in MEM and the consumer forwards from WB.
- Branch/jump flush: EX_VALID and EX_PC_SOURCE != 0.
  - Effect: PC_SOURCE = EX_PC_SOURCE, kill_de = 1, DE_VALID <= 0. The second 0 covers the stale IR returned by the synchronous instruction memory.
  - Flush has priority over stall; no stall is asserted in a flush cycle.
- Forwarding: computed in DE against the EX producer (MEM next cycle), the MEM producer (WB next cycle) and the WB producer (hold register next cycle).
  - Priority EX > MEM > WB. Register x0 never matches.
  - Result registered into FWD_A/FWD_B when not stalled. On a stall, FWD_x <= 0 (bubble).
- Interrupt FSM with states RUN, DRAIN, TRAP. int_pending is set by INTR and cleared in TRAP.
  - RUN -> DRAIN when int_pending & MIE & DE_VALID & no flush & no stall.
  - Entry cycle (Mealy): EPC_SAVE = 1, EPC_VALUE = DE_PC, kill_de = 1, PC_WRITE = 0, DE_VALID <= 0.
  - DRAIN: PC_WRITE = 0, fetch_ok = 0, kill_de = 1. A down-counter loaded with DRAIN_CYCLES-1 runs out -> TRAP.
  - TRAP: PC_SOURCE = 4, PC_WRITE = 1, INT_TAKEN = 1, then -> RUN. DE_VALID becomes 1 one cycle after RUN resumes fetch.
- PC_SOURCE = 0 otherwise. PC_WRITE = 1 otherwise.

## Timing
- Reset values: state RUN, counter 0, int_pending 0, all VALID 0, FWD_A/B 0, EPC_SAVE 0, INT_TAKEN 0, PC_WRITE 1, IF_DE_WRITE 1, PC_SOURCE 0.
- DE_VALID first rises on the second rising edge after RESET_N deasserts; this covers the synchronous IR latency.
- Stall, flush, EPC_SAVE and PC_SOURCE are combinational from the current stage state. Valid bits, FWD_x, the FSM and int_pending are registered.
- Interrupt latency from the entry cycle to the MTVEC fetch is DRAIN_CYCLES + 1 cycles.
- INTR arriving while MIE = 0 stays pending until MIE = 1.
- Reset mid-DRAIN returns to RUN with no trap taken.
- INTR in a flush or stall cycle: entry is deferred to the first clean cycle with DE_VALID = 1.

## Test plan
- Load-use, lw x5 then add x6,x5,x1 -> one cycle of PC_WRITE = 0 and a bubble in EX; the add executes with FWD_A = 2.
- add x5 then sub x7,x5,x5 back-to-back -> FWD_A = 1 and FWD_B = 1 in the sub's EX cycle; no stall.
- Taken beq in EX with EX_PC_SOURCE = 2 -> PC_SOURCE = 2; DE and the next fetched instruction both invalid; fall-through instructions never reach MEM_VALID.
- Writes to x0 in EX, MEM and WB with DE reading x0 -> FWD = 0, no stall.
- INTR with MIE = 1 and DE_PC = 0x40 -> EPC_SAVE with 0x40. Then 3 DRAIN cycles, then TRAP (PC_SOURCE = 4, INT_TAKEN pulse), then RUN.
- RESET_N pulsed during DRAIN -> all outputs at reset values immediately; no INT_TAKEN afterward.

Source files
------------

// File: rtl/otter_hazard_ctrl.sv
// otter_hazard_ctrl: pipeline sequencing for the 5-stage OTTER core.
// Owns the stage valid bits, load-use stall, branch flush, registered
// EX-operand forwarding selects and the interrupt drain/trap sequence.
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | normal issue; may accept a pending interrupt on a clean cycle
// DRAIN | fetch frozen, bubbles pushed until EX/MEM/WB are empty
// TRAP  | redirect fetch to MTVEC, pulse INT_TAKEN, then back to RUN
module otter_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [4:0]  DE_RS1_ADDR,
  input  logic [4:0]  DE_RS2_ADDR,
  input  logic        DE_RS1_USED,
  input  logic        DE_RS2_USED,
  input  logic [31:0] DE_PC,
  input  logic [4:0]  EX_RD_ADDR,
  input  logic [4:0]  MEM_RD_ADDR,
  input  logic [4:0]  WB_RD_ADDR,
  input  logic        EX_REGWRITE,
  input  logic        MEM_REGWRITE,
  input  logic        WB_REGWRITE,
  input  logic        EX_MEMREAD,
  input  logic [2:0]  EX_PC_SOURCE,
  input  logic        INTR,
  input  logic        MIE,
  output logic        PC_WRITE,
  output logic [2:0]  PC_SOURCE,
  output logic        IF_DE_WRITE,
  output logic        DE_VALID,
  output logic        EX_VALID,
  output logic        MEM_VALID,
  output logic        WB_VALID,
  output logic [1:0]  FWD_A,
  output logic [1:0]  FWD_B,
  output logic        EPC_SAVE,
  output logic [31:0] EPC_VALUE,
  output logic        INT_TAKEN
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_TRAP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_pend;
  logic          r_if_valid;
  logic          r_de_valid, r_ex_valid, r_mem_valid, r_wb_valid;
  logic [1:0]    r_fwd_a, r_fwd_b;

  logic       w_ex_prod, w_mem_prod, w_wb_prod;
  logic       w_load_use, w_flush, w_stall, w_enter;
  logic       w_drain, w_trap, w_kill_de, w_fetch_ok;
  logic [1:0] w_fwd_a, w_fwd_b;

  assign w_ex_prod  = EX_REGWRITE  & r_ex_valid  & (EX_RD_ADDR  != 5'd0);
  assign w_mem_prod = MEM_REGWRITE & r_mem_valid & (MEM_RD_ADDR != 5'd0);
  assign w_wb_prod  = WB_REGWRITE  & r_wb_valid  & (WB_RD_ADDR  != 5'd0);

  assign w_load_use = w_ex_prod & EX_MEMREAD & r_de_valid &
                      ((DE_RS1_USED & (DE_RS1_ADDR == EX_RD_ADDR)) |
                       (DE_RS2_USED & (DE_RS2_ADDR == EX_RD_ADDR)));
  assign w_flush    = r_ex_valid & (EX_PC_SOURCE != 3'd0);
  // a redirect discards the consumer anyway, so it wins over the stall
  assign w_stall    = w_load_use & ~w_flush;

  assign w_drain    = (r_state == ST_DRAIN);
  assign w_trap     = (r_state == ST_TRAP);
  assign w_enter    = (r_state == ST_RUN) & r_pend & MIE & r_de_valid &
                      ~w_flush & ~w_stall;
  assign w_kill_de  = w_stall | w_flush | w_enter | w_drain;
  assign w_fetch_ok = r_if_valid & ~w_drain;

  assign PC_WRITE    = ~(w_stall | w_enter | w_drain);
  assign IF_DE_WRITE = ~w_stall;
  assign PC_SOURCE   = w_trap ? 3'd4 : (w_flush ? EX_PC_SOURCE : 3'd0);
  assign EPC_SAVE    = w_enter;
  assign EPC_VALUE   = DE_PC;
  assign INT_TAKEN   = w_trap;

  assign DE_VALID  = r_de_valid;
  assign EX_VALID  = r_ex_valid;
  assign MEM_VALID = r_mem_valid;
  assign WB_VALID  = r_wb_valid;
  assign FWD_A     = r_fwd_a;
  assign FWD_B     = r_fwd_b;

  // forwarding select for the DE sources, youngest producer first
  always_comb begin
    w_fwd_a = 2'd0;
    w_fwd_b = 2'd0;
    if (DE_RS1_USED && DE_RS1_ADDR != 5'd0) begin
      if (w_ex_prod && DE_RS1_ADDR == EX_RD_ADDR)        w_fwd_a = 2'd1;
      else if (w_mem_prod && DE_RS1_ADDR == MEM_RD_ADDR) w_fwd_a = 2'd2;
      else if (w_wb_prod && DE_RS1_ADDR == WB_RD_ADDR)   w_fwd_a = 2'd3;
    end
    if (DE_RS2_USED && DE_RS2_ADDR != 5'd0) begin
      if (w_ex_prod && DE_RS2_ADDR == EX_RD_ADDR)        w_fwd_b = 2'd1;
      else if (w_mem_prod && DE_RS2_ADDR == MEM_RD_ADDR) w_fwd_b = 2'd2;
      else if (w_wb_prod && DE_RS2_ADDR == WB_RD_ADDR)   w_fwd_b = 2'd3;
    end
  end

  // stage valid shift and registered forwarding selects
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_de_valid  <= 1'b0;
      r_ex_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_fwd_a     <= 2'd0;
      r_fwd_b     <= 2'd0;
    end else begin
      r_wb_valid  <= r_mem_valid;
      r_mem_valid <= r_ex_valid;
      r_ex_valid  <= r_de_valid & ~w_kill_de;
      if (w_stall)      r_de_valid <= r_de_valid;
      else if (w_enter) r_de_valid <= 1'b0;
      else              r_de_valid <= w_fetch_ok & ~w_flush;
      if (w_stall) begin
        r_fwd_a <= 2'd0;
        r_fwd_b <= 2'd0;
      end else begin
        r_fwd_a <= w_fwd_a;
        r_fwd_b <= w_fwd_b;
      end
    end
  end

  // interrupt FSM, drain counter, pending latch and IR-latency flag
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= ST_RUN;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_if_valid <= 1'b0;
    end else begin
      r_pend     <= w_trap ? 1'b0 : (r_pend | INTR);
      // the IR is one cycle behind the PC, so fetch becomes usable a cycle
      // after the PC is running on a real address
      r_if_valid <= w_trap | ((r_state == ST_RUN) & ~w_enter);
      case (r_state)
        ST_RUN: begin
          if (w_enter) begin
            r_state <= ST_DRAIN;
            r_cnt   <= CNT_LOAD;
          end
        end
        ST_DRAIN: begin
          if (r_cnt == '0) r_state <= ST_TRAP;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_TRAP: r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Directed bench for otter_hazard_ctrl: vector table for single-cycle
// hazard decisions, hand sequences for multi-cycle behaviour.
module tb_otter_hazard_ctrl;

  logic        CLK, RESET_N;
  logic [4:0]  DE_RS1_ADDR, DE_RS2_ADDR;
  logic        DE_RS1_USED, DE_RS2_USED;
  logic [31:0] DE_PC;
  logic [4:0]  EX_RD_ADDR, MEM_RD_ADDR, WB_RD_ADDR;
  logic        EX_REGWRITE, MEM_REGWRITE, WB_REGWRITE, EX_MEMREAD;
  logic [2:0]  EX_PC_SOURCE;
  logic        INTR, MIE;
  logic        PC_WRITE, IF_DE_WRITE, DE_VALID, EX_VALID, MEM_VALID, WB_VALID;
  logic [2:0]  PC_SOURCE;
  logic [1:0]  FWD_A, FWD_B;
  logic        EPC_SAVE, INT_TAKEN;
  logic [31:0] EPC_VALUE;

  int n_vec = 0;
  int n_err = 0;

  otter_hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .DE_RS1_ADDR(DE_RS1_ADDR), .DE_RS2_ADDR(DE_RS2_ADDR),
    .DE_RS1_USED(DE_RS1_USED), .DE_RS2_USED(DE_RS2_USED), .DE_PC(DE_PC),
    .EX_RD_ADDR(EX_RD_ADDR), .MEM_RD_ADDR(MEM_RD_ADDR), .WB_RD_ADDR(WB_RD_ADDR),
    .EX_REGWRITE(EX_REGWRITE), .MEM_REGWRITE(MEM_REGWRITE), .WB_REGWRITE(WB_REGWRITE),
    .EX_MEMREAD(EX_MEMREAD), .EX_PC_SOURCE(EX_PC_SOURCE),
    .INTR(INTR), .MIE(MIE),
    .PC_WRITE(PC_WRITE), .PC_SOURCE(PC_SOURCE), .IF_DE_WRITE(IF_DE_WRITE),
    .DE_VALID(DE_VALID), .EX_VALID(EX_VALID), .MEM_VALID(MEM_VALID), .WB_VALID(WB_VALID),
    .FWD_A(FWD_A), .FWD_B(FWD_B),
    .EPC_SAVE(EPC_SAVE), .EPC_VALUE(EPC_VALUE), .INT_TAKEN(INT_TAKEN)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       ex_rw, mem_rw, wb_rw, ex_mr;
    logic [2:0] src;
    logic       e_pcw, e_ifde;
    logic [2:0] e_psrc;
    logic [1:0] e_fa, e_fb;
    logic       e_de, e_ex;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic neutral();
    DE_RS1_ADDR = 5'd0; DE_RS2_ADDR = 5'd0; DE_RS1_USED = 1'b0; DE_RS2_USED = 1'b0;
    EX_RD_ADDR = 5'd0; MEM_RD_ADDR = 5'd0; WB_RD_ADDR = 5'd0;
    EX_REGWRITE = 1'b0; MEM_REGWRITE = 1'b0; WB_REGWRITE = 1'b0;
    EX_MEMREAD = 1'b0; EX_PC_SOURCE = 3'd0;
  endtask

  task automatic setv(input vec_t v);
    DE_RS1_ADDR = v.rs1; DE_RS2_ADDR = v.rs2; DE_RS1_USED = v.u1; DE_RS2_USED = v.u2;
    EX_RD_ADDR = v.ex_rd; MEM_RD_ADDR = v.mem_rd; WB_RD_ADDR = v.wb_rd;
    EX_REGWRITE = v.ex_rw; MEM_REGWRITE = v.mem_rw; WB_REGWRITE = v.wb_rw;
    EX_MEMREAD = v.ex_mr; EX_PC_SOURCE = v.src;
  endtask

  // rs1 rs2 u1 u2 exrd memrd wbrd exrw memrw wbrw exmr src | pcw ifde psrc fa fb de ex
  initial begin
    vt[0]  = '{5'd1, 5'd2, 1, 1, 5'd3, 5'd4, 5'd5, 1, 1, 1, 0, 3'd0, 1, 1, 3'd0, 2'd0, 2'd0, 1, 1};
    vt[1]  = '{5'd5, 5'd5, 1, 1, 5'd5, 5'd4, 5'd3, 1, 1, 1, 0, 3'd0, 1, 1, 3'd0, 2'd1, 2'd1, 1, 1};
    vt[2]  = '{5'd6, 5'd7, 1, 1, 5'd3, 5'd6, 5'd7, 1, 1, 1, 0, 3'd0, 1, 1, 3'd0, 2'd2, 2'd3, 1, 1};
    vt[3]  = '{5'd8, 5'd8, 1, 1, 5'd8, 5'd8, 5'd8, 1, 1, 1, 0, 3'd0, 1, 1, 3'd0, 2'd1, 2'd1, 1, 1};
    vt[4]  = '{5'd8, 5'd9, 1, 1, 5'd8, 5'd8, 5'd9, 0, 1, 1, 0, 3'd0, 1, 1, 3'd0, 2'd2, 2'd3, 1, 1};
    vt[5]  = '{5'd0, 5'd0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 1, 1, 1, 3'd0, 1, 1, 3'd0, 2'd0, 2'd0, 1, 1};
    vt[6]  = '{5'd5, 5'd1, 1, 1, 5'd5, 5'd4, 5'd3, 1, 1, 1, 1, 3'd0, 0, 0, 3'd0, 2'd0, 2'd0, 1, 0};
    vt[7]  = '{5'd1, 5'd5, 1, 0, 5'd5, 5'd4, 5'd3, 1, 1, 1, 1, 3'd0, 1, 1, 3'd0, 2'd0, 2'd0, 1, 1};
    vt[8]  = '{5'd1, 5'd2, 1, 1, 5'd3, 5'd4, 5'd5, 1, 1, 1, 0, 3'd2, 1, 1, 3'd2, 2'd0, 2'd0, 0, 0};
    vt[9]  = '{5'd5, 5'd1, 1, 1, 5'd5, 5'd4, 5'd3, 1, 1, 1, 1, 3'd3, 1, 1, 3'd3, 2'd1, 2'd0, 0, 0};
    vt[10] = '{5'd5, 5'd5, 1, 1, 5'd5, 5'd4, 5'd3, 0, 1, 1, 1, 3'd0, 1, 1, 3'd0, 2'd0, 2'd0, 1, 1};
    vt[11] = '{5'd2, 5'd9, 1, 1, 5'd3, 5'd9, 5'd2, 1, 1, 1, 0, 3'd1, 1, 1, 3'd1, 2'd3, 2'd2, 0, 0};
    vt[12] = '{5'd4, 5'd4, 1, 0, 5'd3, 5'd4, 5'd4, 1, 1, 1, 0, 3'd0, 1, 1, 3'd0, 2'd2, 2'd0, 1, 1};
  end

  initial begin
    int hits;
    RESET_N = 1'b0; INTR = 1'b0; MIE = 1'b0; DE_PC = 32'h40;
    neutral();
    #12;
    chk("rst_pc_write", PC_WRITE, 1);
    chk("rst_if_de_write", IF_DE_WRITE, 1);
    chk("rst_pc_source", PC_SOURCE, 0);
    chk("rst_valids", {DE_VALID, EX_VALID, MEM_VALID, WB_VALID}, 0);
    chk("rst_fwd", {FWD_A, FWD_B}, 0);
    chk("rst_strobes", {EPC_SAVE, INT_TAKEN}, 0);
    @(negedge CLK); RESET_N = 1'b1;
    @(posedge CLK); #1 chk("de_after_edge1", DE_VALID, 0);
    @(posedge CLK); #1 chk("de_after_edge2", DE_VALID, 1);

    // table vectors, each from a fully valid pipeline
    for (int i = 0; i < 13; i++) begin
      neutral();
      repeat (5) @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("v%0d_all_valid", i), {DE_VALID, EX_VALID, MEM_VALID, WB_VALID}, 4'hf);
      setv(vt[i]);
      #1;
      chk($sformatf("v%0d_pc_write", i), PC_WRITE, vt[i].e_pcw);
      chk($sformatf("v%0d_if_de_write", i), IF_DE_WRITE, vt[i].e_ifde);
      chk($sformatf("v%0d_pc_source", i), PC_SOURCE, vt[i].e_psrc);
      @(posedge CLK); #1;
      chk($sformatf("v%0d_fwd_a", i), FWD_A, vt[i].e_fa);
      chk($sformatf("v%0d_fwd_b", i), FWD_B, vt[i].e_fb);
      chk($sformatf("v%0d_de_valid", i), DE_VALID, vt[i].e_de);
      chk($sformatf("v%0d_ex_valid", i), EX_VALID, vt[i].e_ex);
    end

    // lw x5 ; add x6,x5,x1 : one stall cycle then forward from WB
    neutral(); repeat (5) @(posedge CLK);
    @(negedge CLK);
    DE_RS1_ADDR = 5'd5; DE_RS2_ADDR = 5'd1; DE_RS1_USED = 1; DE_RS2_USED = 1;
    EX_RD_ADDR = 5'd5; EX_REGWRITE = 1; EX_MEMREAD = 1;
    #1 chk("lu_stall_pcw", PC_WRITE, 0);
    @(negedge CLK);
    EX_RD_ADDR = 5'd0; EX_REGWRITE = 0; EX_MEMREAD = 0;
    MEM_RD_ADDR = 5'd5; MEM_REGWRITE = 1;
    #1 chk("lu_after_pcw", PC_WRITE, 1);
    chk("lu_bubble_ex", EX_VALID, 0);
    @(posedge CLK); #1;
    chk("lu_fwd_a", FWD_A, 2);
    chk("lu_fwd_b", FWD_B, 0);
    chk("lu_add_in_ex", EX_VALID, 1);

    // taken branch: fall-through instructions never reach MEM
    neutral(); repeat (5) @(posedge CLK);
    @(negedge CLK); EX_PC_SOURCE = 3'd2;
    #1 chk("br_pc_source", PC_SOURCE, 2);
    @(posedge CLK); #1;
    EX_PC_SOURCE = 3'd0;
    chk("br_e1", {DE_VALID, EX_VALID, MEM_VALID}, 3'b001);
    @(posedge CLK); #1 chk("br_e2", {DE_VALID, EX_VALID, MEM_VALID}, 3'b100);
    @(posedge CLK); #1 chk("br_e3", {EX_VALID, MEM_VALID}, 2'b10);

    // interrupt arriving in a flush cycle, entry deferred, full trap
    neutral(); repeat (5) @(posedge CLK);
    MIE = 1'b1;
    @(negedge CLK); INTR = 1'b1; EX_PC_SOURCE = 3'd2;
    #1 chk("irq_flush_no_epc", EPC_SAVE, 0);
    @(negedge CLK); INTR = 1'b0; EX_PC_SOURCE = 3'd0;
    #1 chk("irq_de_invalid", DE_VALID, 0);
    chk("irq_defer_epc", EPC_SAVE, 0);
    @(negedge CLK);
    #1 chk("irq_entry_epc_save", EPC_SAVE, 1);
    chk("irq_entry_epc_value", EPC_VALUE, 32'h40);
    chk("irq_entry_pcw", PC_WRITE, 0);
    for (int d = 0; d < 3; d++) begin
      @(negedge CLK); #1;
      chk($sformatf("drain%0d_pcw", d), PC_WRITE, 0);
      chk($sformatf("drain%0d_taken", d), INT_TAKEN, 0);
      chk($sformatf("drain%0d_de", d), DE_VALID, 0);
    end
    @(negedge CLK); #1;
    chk("trap_pc_source", PC_SOURCE, 4);
    chk("trap_int_taken", INT_TAKEN, 1);
    chk("trap_pcw", PC_WRITE, 1);
    @(negedge CLK); #1;
    chk("run1_taken", INT_TAKEN, 0);
    chk("run1_pc_source", PC_SOURCE, 0);
    chk("run1_de", DE_VALID, 0);
    @(negedge CLK); #1;
    chk("run2_de", DE_VALID, 1);
    chk("run2_no_reentry", EPC_SAVE, 0);

    // MIE=0 keeps request pending; reset during DRAIN cancels the trap
    MIE = 1'b0;
    @(negedge CLK); INTR = 1'b1;
    @(negedge CLK); INTR = 1'b0;
    for (int d = 0; d < 3; d++) begin
      @(negedge CLK); #1 chk($sformatf("mie0_wait%0d", d), EPC_SAVE, 0);
    end
    @(negedge CLK); MIE = 1'b1;
    #1 chk("mie1_entry", EPC_SAVE, 1);
    @(negedge CLK); #1 chk("mid_drain_pcw", PC_WRITE, 0);
    RESET_N = 1'b0;
    #1;
    chk("rstdrain_pcw", PC_WRITE, 1);
    chk("rstdrain_valids", {DE_VALID, EX_VALID, MEM_VALID, WB_VALID}, 0);
    chk("rstdrain_taken", INT_TAKEN, 0);
    chk("rstdrain_pc_source", PC_SOURCE, 0);
    @(negedge CLK); RESET_N = 1'b1;
    hits = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK); #1;
      if (INT_TAKEN || PC_SOURCE == 3'd4) hits++;
    end
    chk("rstdrain_no_trap", hits, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
